// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core:
// forwarding-select encodings, register-id width and the hazard FSM states.
package core_pkg;

    localparam int unsigned REG_BITS = 3;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_IMM   = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_t;

endpackage : core_pkg

// File: rtl/fwd_select.sv
// Per-operand forwarding priority compare: EX beats MEM beats register file,
// with an optional immediate override for operand B.
module fwd_select #(
    parameter int unsigned REG_BITS = core_pkg::REG_BITS,
    parameter bit          R0_ZERO  = 1'b1,
    parameter bit          IMM_EN   = 1'b0
) (
    input  logic [REG_BITS-1:0] rs_i,
    input  logic                use_i,
    input  logic                use_imm_i,
    input  logic [REG_BITS-1:0] ex_rd_i,
    input  logic                ex_regwrite_i,
    input  logic [REG_BITS-1:0] mem_rd_i,
    input  logic                mem_regwrite_i,
    output logic [1:0]          sel_c_o,
    output logic                ex_hit_c_o
);

    logic mem_hit;

    // A zero destination never matches when R0 is hard-wired.
    assign ex_hit_c_o = ex_regwrite_i & use_i & (ex_rd_i == rs_i)
                      & ~(R0_ZERO & (ex_rd_i == '0));
    assign mem_hit    = mem_regwrite_i & use_i & (mem_rd_i == rs_i)
                      & ~(R0_ZERO & (mem_rd_i == '0));

    always_comb begin
        sel_c_o = core_pkg::FWD_REG;
        if (IMM_EN && use_imm_i) begin
            sel_c_o = core_pkg::FWD_IMM;
        end else if (ex_hit_c_o) begin
            sel_c_o = core_pkg::FWD_EXMEM;
        end else if (mem_hit) begin
            sel_c_o = core_pkg::FWD_MEMWB;
        end
    end

endmodule : fwd_select

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard/forwarding controller: registered EX operand selects,
// combinational pipeline enables for stall/flush/freeze, saturating event counters.
module hazard_forward_unit #(
    parameter int unsigned REG_BITS = core_pkg::REG_BITS,
    parameter bit          R0_ZERO  = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_use_imm,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                idex_write,
    output logic                idex_bubble,
    output logic                ifid_flush,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    core_pkg::hz_state_t state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]       sel_a_c, sel_b_c;
    logic             ex_hit_a, ex_hit_b, load_use;
    logic             stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    fwd_select #(.REG_BITS(REG_BITS), .R0_ZERO(R0_ZERO), .IMM_EN(1'b0)) u_sel_a (
        .rs_i(id_rs1), .use_i(id_use_rs1), .use_imm_i(1'b0),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .sel_c_o(sel_a_c), .ex_hit_c_o(ex_hit_a)
    );

    fwd_select #(.REG_BITS(REG_BITS), .R0_ZERO(R0_ZERO), .IMM_EN(1'b1)) u_sel_b (
        .rs_i(id_rs2), .use_i(id_use_rs2), .use_imm_i(id_use_imm),
        .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .sel_c_o(sel_b_c), .ex_hit_c_o(ex_hit_b)
    );

    // An immediate B operand cannot depend on the load.
    assign load_use = ex_memread & (ex_hit_a | (ex_hit_b & ~id_use_imm));

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;

        case (state_q)
            core_pkg::RUN:    if (mem_busy)  state_d = core_pkg::FREEZE;
            core_pkg::FREEZE: if (!mem_busy) state_d = core_pkg::RUN;
            default:          state_d = core_pkg::RUN;
        endcase

        // Priority: reset, freeze, taken branch (squashes ID), load-use stall.
        if (reset) begin
            state_d = core_pkg::RUN;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            fwd_a_d     = core_pkg::FWD_REG;
            fwd_b_d     = core_pkg::FWD_REG;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            fwd_a_d     = core_pkg::FWD_REG;
            fwd_b_d     = core_pkg::FWD_REG;
        end else begin
            fwd_a_d = sel_a_c;
            fwd_b_d = sel_b_c;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= core_pkg::RUN;
            fwd_a_q     <= core_pkg::FWD_REG;
            fwd_b_q     <= core_pkg::FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; a second instance with 2-bit
// counters exercises saturation.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, id_use_imm;
    logic       ex_regwrite, ex_memread, mem_regwrite, branch_taken, mem_busy;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_write, ifid_write, idex_write, idex_bubble, ifid_flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0] s_fwd_a_sel, s_fwd_b_sel;
    logic       s_pc_write, s_ifid_write, s_idex_write, s_idex_bubble, s_ifid_flush;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_BITS(3), .R0_ZERO(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_forward_unit #(.REG_BITS(3), .R0_ZERO(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
        .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_use_imm = 1'b0;
        ex_rd = 3'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 3'd0; mem_regwrite = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use_r(input logic [2:0] r);
        idle();
        ex_rd = r; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs1 = r; id_use_rs1 = 1'b1;
    endtask

    initial begin
        idle();
        // Reset with mem_busy high: enables still forced on.
        reset = 1'b1; mem_busy = 1'b1;
        #1;
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_idex_write", 32'(idex_write), 32'd1);
        step(); step();
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        reset = 1'b0;
        idle();
        step();

        // EX forward to A.
        idle(); ex_rd = 3'd1; ex_regwrite = 1'b1; id_rs1 = 3'd1; id_use_rs1 = 1'b1;
        #1;
        chk("exfwd_pc_write", 32'(pc_write), 32'd1);
        chk("exfwd_bubble", 32'(idex_bubble), 32'd0);
        step();
        chk("exfwd_a", 32'(fwd_a_sel), 32'd1);
        chk("exfwd_stall_cnt", 32'(stall_cnt), 32'd0);

        // EX vs MEM priority on B, then MEM only, then immediate override.
        idle(); ex_rd = 3'd2; ex_regwrite = 1'b1; mem_rd = 3'd2; mem_regwrite = 1'b1;
        id_rs2 = 3'd2; id_use_rs2 = 1'b1;
        step();
        chk("b_ex_wins", 32'(fwd_b_sel), 32'd1);
        ex_regwrite = 1'b0;
        step();
        chk("b_mem", 32'(fwd_b_sel), 32'd2);
        id_use_imm = 1'b1;
        step();
        chk("b_imm", 32'(fwd_b_sel), 32'd3);

        // Load-use stall, then MEM forward with no second stall.
        load_use_r(3'd3);
        #1;
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_ifid_write", 32'(ifid_write), 32'd0);
        chk("lu_idex_write", 32'(idex_write), 32'd1);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        step();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_fwd_a_bubble", 32'(fwd_a_sel), 32'd0);
        idle(); mem_rd = 3'd3; mem_regwrite = 1'b1; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
        #1;
        chk("lu2_pc_write", 32'(pc_write), 32'd1);
        chk("lu2_bubble", 32'(idex_bubble), 32'd0);
        step();
        chk("lu2_fwd_a", 32'(fwd_a_sel), 32'd2);
        chk("lu2_stall_cnt", 32'(stall_cnt), 32'd1);

        // Load-use together with a taken branch: branch wins.
        load_use_r(3'd3); branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_bubble", 32'(idex_bubble), 32'd1);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        step();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("br_fwd_a", 32'(fwd_a_sel), 32'd0);

        // Freeze during a pending load-use.
        idle(); ex_rd = 3'd5; ex_regwrite = 1'b1; id_rs1 = 3'd5; id_use_rs1 = 1'b1;
        step();
        chk("pre_frz_fwd_a", 32'(fwd_a_sel), 32'd1);
        load_use_r(3'd5); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_pc_write", 32'(pc_write), 32'd0);
            chk("frz_idex_write", 32'(idex_write), 32'd0);
            chk("frz_bubble", 32'(idex_bubble), 32'd0);
            step();
            chk("frz_fwd_a", 32'(fwd_a_sel), 32'd1);
            chk("frz_stall_cnt", 32'(stall_cnt), 32'd1);
        end
        mem_busy = 1'b0;
        #1;
        chk("rel_pc_write", 32'(pc_write), 32'd0);
        chk("rel_bubble", 32'(idex_bubble), 32'd1);
        step();
        chk("rel_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("rel_fwd_a", 32'(fwd_a_sel), 32'd0);

        // R0 destination never forwards or stalls.
        load_use_r(3'd0);
        #1;
        chk("r0_pc_write", 32'(pc_write), 32'd1);
        chk("r0_bubble", 32'(idex_bubble), 32'd0);
        step();
        chk("r0_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("r0_stall_cnt", 32'(stall_cnt), 32'd2);

        // Reset in the middle of a freeze.
        idle(); ex_rd = 3'd1; ex_regwrite = 1'b1; id_rs1 = 3'd1; id_use_rs1 = 1'b1;
        step();
        chk("pre_rst_fwd_a", 32'(fwd_a_sel), 32'd1);
        mem_busy = 1'b1;
        step();
        reset = 1'b1;
        #1;
        chk("rst_frz_pc_write", 32'(pc_write), 32'd1);
        step();
        chk("rst_frz_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_frz_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_frz_flush_cnt", 32'(flush_cnt), 32'd0);
        reset = 1'b0;
        load_use_r(3'd4);
        #1;
        chk("post_rst_lu_pc_write", 32'(pc_write), 32'd0);
        step();
        chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd1);

        // Held load-use keeps stalling; 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) step();
        chk("sat_wide_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("sat_narrow_stall_cnt", 32'(s_stall_cnt), 32'd3);
        step();
        chk("sat_narrow_hold", 32'(s_stall_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_forward_unit
